bus_test_responder: RTL and testbench

Memory-mapped responder on the CPU data bus, answering the same single-pulse request/response protocol that `memory_top` serves. It holds the 64-bit test-pass register that drives `o_test_pass`, plus a free-running cycle counter, a sticky status register and a small scratch RAM. Accesses complete with byte, half or word granularity after a programmable latency. It sits beside `memory_top` on the bus and answers only addresses inside its own window.

---
 rtl/bus_test_responder_if.sv | 31 +++
 rtl/bus_test_responder.sv | 203 ++++++++++++++++++++
 tb/tb_bus_test_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_test_responder_if.sv
// Single-pulse request/response bus shared by memory_top and bus_test_responder.
// The master drives the request side, and the responder drives the response side.
interface bus_test_responder_if;
    logic [31:0] i_bus_data;
    logic [31:0] i_bus_address;
    logic        i_bus_DV;
    logic [2:0]  i_bhw;
    logic        i_write_notread;
    logic [31:0] o_bus_data;
    logic        o_bus_DV;

    modport slave (
        input  i_bus_data,
        input  i_bus_address,
        input  i_bus_DV,
        input  i_bhw,
        input  i_write_notread,
        output o_bus_data,
        output o_bus_DV
    );

    modport master (
        output i_bus_data,
        output i_bus_address,
        output i_bus_DV,
        output i_bhw,
        output i_write_notread,
        input  o_bus_data,
        input  o_bus_DV
    );
endinterface

// File: rtl/bus_test_responder.sv
// Bus responder that holds the 64-bit test-pass register, a cycle counter, a sticky
// W1C status register and a scratch RAM. Each access completes after LATENCY cycles.
module bus_test_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          LATENCY   = 2,
    parameter int          DEPTH     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    bus_test_responder_if.slave  bus,
    output logic [63:0]          o_test_pass
);
    localparam int AW     = $clog2(DEPTH);
    localparam bit DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        is_byte_q, is_byte_d;
    logic        is_half_q, is_half_d;
    logic        wr_q, wr_d;
    logic [31:0] pass_lo_q, pass_lo_d;
    logic [31:0] pass_hi_q, pass_hi_d;
    logic [31:0] cycle_q, cycle_d;
    logic [2:0]  status_q, status_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ram_q [DEPTH];

    logic        hit;
    logic        commit;
    logic [11:0] acc_off;
    logic [31:0] acc_data;
    logic        acc_byte, acc_half, acc_wr;
    logic [1:0]  lane;
    logic        misaligned, reg_sel, ram_hit, unmapped, do_write, ram_we;
    logic [1:0]  reg_idx;
    logic [9:0]  ram_widx;
    logic [AW-1:0] ram_idx;
    logic [4:0]  shamt;
    logic [31:0] low_mask, wmask, wdata_al, src_word, rd_val, merged;
    logic [2:0]  st_set, st_clr;

    assign hit = bus.i_bus_DV && (bus.i_bus_address[31:12] == BASE_ADDR[31:12]);

    // With single-cycle latency the commit happens on the accepting edge, so decode straight from the bus.
    always_comb begin
        if (DIRECT && state_q == S_IDLE) begin
            acc_off  = bus.i_bus_address[11:0];
            acc_data = bus.i_bus_data;
            acc_byte = (bus.i_bhw == 3'b001);
            acc_half = (bus.i_bhw == 3'b010);
            acc_wr   = bus.i_write_notread;
        end else begin
            acc_off  = addr_q;
            acc_data = data_q;
            acc_byte = is_byte_q;
            acc_half = is_half_q;
            acc_wr   = wr_q;
        end
    end

    assign commit = (state_q == S_WAIT && cnt_q == 4'd0) ||
                    (DIRECT && state_q == S_IDLE && hit);

    assign lane       = acc_off[1:0];
    assign misaligned = (acc_half && lane[0]) || (!acc_byte && !acc_half && lane != 2'd0);
    assign reg_sel    = (acc_off[11:4] == 8'd0);
    assign reg_idx    = acc_off[3:2];
    assign ram_widx   = acc_off[11:2] - 10'h040;
    assign ram_hit    = (acc_off[11:8] != 4'd0) && (ram_widx < 10'(DEPTH));
    assign ram_idx    = ram_widx[AW-1:0];
    assign unmapped   = !(reg_sel || ram_hit);
    assign do_write   = commit && acc_wr && !misaligned && !unmapped;
    assign ram_we     = do_write && ram_hit && i_rst_n;

    // Lane shift and mask are shared by the read extract and the write merge.
    always_comb begin
        shamt    = 5'd0;
        low_mask = 32'hFFFF_FFFF;
        if (acc_byte) begin
            shamt    = {lane, 3'b000};
            low_mask = 32'h0000_00FF;
        end else if (acc_half) begin
            shamt    = {lane[1], 4'b0000};
            low_mask = 32'h0000_FFFF;
        end
    end

    assign wmask    = low_mask << shamt;
    assign wdata_al = (acc_data & low_mask) << shamt;

    always_comb begin
        src_word = 32'd0;
        if (reg_sel) begin
            unique case (reg_idx)
                2'd0: src_word = pass_lo_q;
                2'd1: src_word = pass_hi_q;
                2'd2: src_word = cycle_q;
                2'd3: src_word = {29'd0, status_q};
            endcase
        end else if (ram_hit) begin
            src_word = ram_q[ram_idx];
        end
    end

    assign rd_val = (src_word >> shamt) & low_mask;
    assign merged = (src_word & ~wmask) | (wdata_al & wmask);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        is_byte_d = is_byte_q;
        is_half_d = is_half_q;
        wr_d      = wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (hit) begin
                    addr_d    = bus.i_bus_address[11:0];
                    data_d    = bus.i_bus_data;
                    is_byte_d = (bus.i_bhw == 3'b001);
                    is_half_d = (bus.i_bhw == 3'b010);
                    wr_d      = bus.i_write_notread;
                    cnt_d     = 4'(LATENCY - 1);
                    state_d   = DIRECT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pass_lo_d = pass_lo_q;
        pass_hi_d = pass_hi_q;
        rdata_d   = rdata_q;
        cycle_d   = cycle_q + 32'd1;
        st_set    = {unmapped && commit, hit && state_q != S_IDLE, misaligned && commit};
        st_clr    = 3'd0;
        if (commit) begin
            rdata_d = (acc_wr || misaligned || unmapped) ? 32'd0 : rd_val;
        end
        if (do_write && reg_sel) begin
            unique case (reg_idx)
                2'd0: pass_lo_d = merged;
                2'd1: pass_hi_d = merged;
                2'd2: ;
                2'd3: st_clr = wdata_al[2:0] & wmask[2:0];
            endcase
        end
        // A set event in the same cycle as a clear keeps the bit set.
        status_d = (status_q & ~st_clr) | st_set;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 12'd0;
            data_q    <= 32'd0;
            is_byte_q <= 1'b0;
            is_half_q <= 1'b0;
            wr_q      <= 1'b0;
            pass_lo_q <= 32'd0;
            pass_hi_q <= 32'd0;
            cycle_q   <= 32'd0;
            status_q  <= 3'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            is_byte_q <= is_byte_d;
            is_half_q <= is_half_d;
            wr_q      <= wr_d;
            pass_lo_q <= pass_lo_d;
            pass_hi_q <= pass_hi_d;
            cycle_q   <= cycle_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
        end
    end

    // The scratch RAM is intentionally left uninitialised through reset.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= merged;
        end
    end

    assign bus.o_bus_DV   = (state_q == S_RESP);
    assign bus.o_bus_data = (state_q == S_RESP) ? rdata_q : 32'd0;
    assign o_test_pass    = {pass_hi_q, pass_lo_q};
endmodule

// File: tb/tb_bus_test_responder.sv
// Directed scoreboard bench for bus_test_responder. Expected responses are queued
// when a request is driven, then popped and compared when o_bus_DV is seen.
module tb_bus_test_responder;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          LAT  = 2;
    localparam logic [2:0]  B = 3'b001, H = 3'b010, W = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] test_pass;
    always #5 clk = ~clk;

    bus_test_responder_if bus_if ();

    bus_test_responder #(.BASE_ADDR(BASE), .LATENCY(LAT), .DEPTH(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus_if),
        .o_test_pass (test_pass)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        int          due;
        bit          chk_tp;
        logic [63:0] tp;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          run_cyc = 0;
    logic [31:0] last_rdata = 32'd0;
    logic [63:0] tp_exp = 64'd0;
    logic [31:0] r1, r2;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) run_cyc <= 0;
        else        run_cyc <= run_cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (bus_if.o_bus_DV === 1'b1) begin
            last_rdata <= bus_if.o_bus_data;
            if (sbq.size() == 0) begin
                check("unexpected_dv", {63'd0, bus_if.o_bus_DV}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.tag, "_data"}, {32'd0, bus_if.o_bus_data}, {32'd0, mon_e.data});
                check({mon_e.tag, "_cycle"}, 64'(cyc), 64'(mon_e.due));
                if (mon_e.chk_tp) check({mon_e.tag, "_tp"}, test_pass, mon_e.tp);
                $display("resp %s data=%h cyc=%0d tp=%h", mon_e.tag, bus_if.o_bus_data, cyc, test_pass);
            end
        end else begin
            check("idle_data", {32'd0, bus_if.o_bus_data}, 64'd0);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] b, input logic w);
        bus_if.i_bus_address   = a;
        bus_if.i_bus_data      = d;
        bus_if.i_bhw           = b;
        bus_if.i_write_notread = w;
        bus_if.i_bus_DV        = 1'b1;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 20; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sbq.size() != 0) begin
            check("resp_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    task automatic req(input string tag, input logic [11:0] off, input logic [31:0] d,
                       input logic [2:0] b, input logic w, input logic [31:0] exp, input bit use_cyc);
        exp_t e;
        @(negedge clk);
        issue(BASE | {20'd0, off}, d, b, w);
        e.tag    = tag;
        e.data   = use_cyc ? 32'(run_cyc + LAT) : exp;
        e.due    = cyc + 1 + LAT;
        e.chk_tp = w;
        e.tp     = tp_exp;
        sbq.push_back(e);
        @(negedge clk);
        bus_if.i_bus_DV = 1'b0;
        wait_resp();
    endtask

    task automatic wr(input string tag, input logic [11:0] off, input logic [31:0] d, input logic [2:0] b);
        req(tag, off, d, b, 1'b1, 32'd0, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [11:0] off, input logic [2:0] b, input logic [31:0] exp);
        req(tag, off, 32'hDEAD_BEEF, b, 1'b0, exp, 1'b0);
    endtask

    initial begin
        exp_t e;
        bus_if.i_bus_DV = 1'b0;
        bus_if.i_bus_address = 32'd0;
        bus_if.i_bus_data = 32'd0;
        bus_if.i_bhw = W;
        bus_if.i_write_notread = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dv", {63'd0, bus_if.o_bus_DV}, 64'd0);
        check("rst_data", {32'd0, bus_if.o_bus_data}, 64'd0);
        check("rst_tp", test_pass, 64'd0);
        rst_n = 1'b1;
        rd("rst_status", 12'h00C, W, 32'd0);

        tp_exp = 64'h5;
        wr("wr_lo", 12'h000, 32'h0000_0005, W);
        rd("rd_lo", 12'h000, W, 32'h5);

        wr("ram_clr", 12'h100, 32'h0, W);
        wr("ram_b", 12'h101, 32'hFFFF_FFAA, B);
        wr("ram_h", 12'h102, 32'hFFFF_1234, H);
        rd("ram_w", 12'h100, W, 32'h1234_AA00);
        rd("ram_rb", 12'h101, B, 32'h0000_00AA);
        rd("ram_rh", 12'h102, H, 32'h0000_1234);

        wr("mis_h", 12'h103, 32'h0000_5555, H);
        rd("mis_ram", 12'h100, W, 32'h1234_AA00);
        rd("mis_st", 12'h00C, W, 32'h1);
        wr("mis_clr", 12'h00C, 32'h1, W);
        rd("mis_st0", 12'h00C, W, 32'h0);
        rd("mis_wrd", 12'h102, W, 32'h0);
        rd("mis_st1", 12'h00C, W, 32'h1);
        wr("mis_hclr", 12'h00C, 32'h0001, H);
        rd("mis_st2", 12'h00C, W, 32'h0);

        // Second hit one cycle after the first must be dropped and flag overrun.
        @(negedge clk);
        issue(BASE, 32'd0, W, 1'b0);
        e.tag = "ovr"; e.data = 32'h5; e.due = cyc + 1 + LAT; e.chk_tp = 1'b0; e.tp = 64'd0;
        sbq.push_back(e);
        @(negedge clk);
        @(negedge clk);
        bus_if.i_bus_DV = 1'b0;
        wait_resp();
        repeat (3) @(negedge clk);
        rd("ovr_st", 12'h00C, W, 32'h2);
        wr("ovr_clr", 12'h00C, 32'h2, W);

        @(negedge clk);
        issue(32'h0000_0000, 32'hFFFF_FFFF, W, 1'b1);
        @(negedge clk);
        bus_if.i_bus_DV = 1'b0;
        repeat (6) @(negedge clk);
        rd("miss_st", 12'h00C, W, 32'h0);

        rd("unm_rd", 12'h200, W, 32'h0);
        rd("unm_st", 12'h00C, W, 32'h4);
        wr("unm_bclr", 12'h00C, 32'h0000_0004, B);
        rd("unm_st0", 12'h00C, W, 32'h0);

        wr("ram_top", 12'h13C, 32'h5A5A_A5A5, W);
        rd("ram_topr", 12'h13C, W, 32'h5A5A_A5A5);
        rd("ram_end", 12'h140, W, 32'h0);
        rd("ram_endst", 12'h00C, W, 32'h4);
        wr("ram_endclr", 12'h00C, 32'h4, W);

        tp_exp = 64'hCAFE_F00D_0000_0005;
        wr("hi_nohot", 12'h004, 32'hCAFE_F00D, 3'b011);
        tp_exp = 64'hBEEF_F00D_0000_0005;
        wr("hi_half", 12'h006, 32'h0000_BEEF, H);
        rd("hi_rh", 12'h004, H, 32'h0000_F00D);
        rd("hi_rb", 12'h007, B, 32'h0000_00BE);

        // Two CYCLE reads issued exactly 10 cycles apart.
        @(negedge clk);
        issue(BASE | 32'h008, 32'd0, W, 1'b0);
        e.tag = "cyc1"; e.data = 32'(run_cyc + LAT); e.due = cyc + 1 + LAT; e.chk_tp = 1'b0;
        sbq.push_back(e);
        @(negedge clk);
        bus_if.i_bus_DV = 1'b0;
        repeat (8) @(negedge clk);
        r1 = last_rdata;
        req("cyc2", 12'h008, 32'd0, W, 1'b0, 32'd0, 1'b1);
        r2 = last_rdata;
        check("cycle_diff", {32'd0, r2 - r1}, 64'd10);
        wr("cyc_wr", 12'h008, 32'h0, W);
        req("cyc3", 12'h008, 32'd0, W, 1'b0, 32'd0, 1'b1);

        @(negedge clk);
        force dut.cycle_q = 32'hFFFF_FFFD;
        #1;
        release dut.cycle_q;
        rd("cyc_wrap", 12'h008, W, 32'h0000_0000);

        // Reset during WAIT of a TEST_PASS_HI write.
        @(negedge clk);
        issue(BASE | 32'h004, 32'h1111_2222, W, 1'b1);
        @(negedge clk);
        bus_if.i_bus_DV = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_tp", test_pass, 64'd0);
        repeat (4) @(negedge clk);
        check("rstmid_dv", {63'd0, bus_if.o_bus_DV}, 64'd0);
        tp_exp = 64'h77;
        wr("post_wr", 12'h000, 32'h77, W);
        rd("post_hi", 12'h004, W, 32'h0);
        req("post_cyc", 12'h008, 32'd0, W, 1'b0, 32'd0, 1'b1);
        check("post_tp", test_pass, 64'h77);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
